// File: rtl/elem_chk_pkg.sv
// Shared types and golden model for the logic-element result checker.
// Op encodings, checker FSM states and the golden() reference function.
package elem_chk_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } chk_state_t;

  function automatic logic [DATA_W-1:0] golden(
    input logic [1:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = '0;
    unique case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/elem_chk_fifo.sv
// Width-agnostic synchronous FIFO with sync flush and async active-low reset.
// Ports: clk, rst_n, clear, push/wdata, pop/rdata (head), full, empty.
module elem_chk_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign rdata   = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clear) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; only entries behind the pointers are read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/elem_result_checker.sv
// Response checker for AND/OR/XOR/NOR elements: buffers {op,a,b,res}, recomputes,
// counts pass/fail, signals done after eot; first-fail record when FAIL_CAPTURE_EN.
module elem_result_checker
  import elem_chk_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_res,
  input  logic             eot,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             done,
  output logic             ff_valid,
  output logic [1:0]       ff_op,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH-1:0] ff_res,
  output logic [WIDTH-1:0] ff_exp
);

  localparam int DW = 2 + 3 * WIDTH;

  chk_state_t state_q;
  chk_state_t state_d;

  logic [DW-1:0]    head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [1:0]       h_op;
  logic [WIDTH-1:0] h_a;
  logic [WIDTH-1:0] h_b;
  logic [WIDTH-1:0] h_res;
  logic [WIDTH-1:0] h_exp;
  logic             match;
  logic             eot_seen;

  assign eot_seen = (state_q != S_RUN);
  // rst_n term keeps ready low while the block is held in reset.
  assign in_ready = rst_n & ~full & ~eot_seen & ~clear;
  assign push     = in_valid & in_ready;
  assign pop      = ~empty & ~clear;

  elem_chk_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .wdata ({in_op, in_a, in_b, in_res}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign {h_op, h_a, h_b, h_res} = head;
  assign h_exp = golden(h_op, h_a, h_b);
  assign match = (h_exp == h_res);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (clear) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (pop) begin
      if (match) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // Once draining, no push can arrive, so empty means nothing left to check.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (eot) state_d = S_DRAIN;
      S_DRAIN: if (empty) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
    if (clear) state_d = S_RUN;
  end

  assign done = (state_q == S_DONE);

`ifdef FAIL_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid <= 1'b0;
      ff_op    <= '0;
      ff_a     <= '0;
      ff_b     <= '0;
      ff_res   <= '0;
      ff_exp   <= '0;
    end else if (clear) begin
      ff_valid <= 1'b0;
      ff_op    <= '0;
      ff_a     <= '0;
      ff_b     <= '0;
      ff_res   <= '0;
      ff_exp   <= '0;
    end else if (pop && !match && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_op    <= h_op;
      ff_a     <= h_a;
      ff_b     <= h_b;
      ff_res   <= h_res;
      ff_exp   <= h_exp;
    end
  end
`else
  assign ff_valid = 1'b0;
  assign ff_op    = '0;
  assign ff_a     = '0;
  assign ff_b     = '0;
  assign ff_res   = '0;
  assign ff_exp   = '0;
`endif

endmodule
